clk_rst_sequencer: RTL

Synthesizable, parametrised reset/calibration sequencer for the memory-slave test environment. It replaces the fixed two-step reset / `init_calib_complete` release with:
- a per-channel reset release staggered in time;
- a per-channel clock-enable divider;
- a runtime recalibration request.

It sits between the bench clock source and the AXI memory-slave channels. It drives their resets, their clock enables and the global calibration-done flag.

---
 rtl/clk_rst_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// clk_rst_sequencer
//
// Reset / calibration sequencer for the memory-slave channels. After reset or
// a recalibration request it holds every channel in reset for RESET_CYCLES
// edges. It then releases the channels in index order, one every
// STAGGER_CYCLES edges. CALIB_CYCLES edges after the last release it raises
// init_calib_complete. Each released channel also gets a clock-enable pulse
// from its own divider.
//
// Ports
//   clk                  in   single clock, all state on rising edge
//   reset                in   asynchronous active-high reset
//   recal_req            in   recalibration request, sampled every edge
//   ch_reset[NUM_CH]     out  per-channel active-high reset (registered)
//   ch_en[NUM_CH]        out  per-channel clock-enable pulse (registered)
//   init_calib_complete  out  sequence finished (registered)
//   state[1:0]           out  0 RESET, 1 RELEASE, 2 CALIB, 3 DONE
//   recal_count[7:0]     out  saturating count of accepted recalibrations
// -----------------------------------------------------------------------------
module clk_rst_sequencer #(
  parameter int                      NUM_CH         = 4,
  parameter int                      DIV_W          = 8,
  parameter logic [NUM_CH*DIV_W-1:0] CH_DIV         = {8'd8, 8'd4, 8'd2, 8'd1},
  parameter int                      CNT_W          = 16,
  parameter int                      RESET_CYCLES   = 16,
  parameter int                      STAGGER_CYCLES = 4,
  parameter int                      CALIB_CYCLES   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recal_req,
  output logic [NUM_CH-1:0] ch_reset,
  output logic [NUM_CH-1:0] ch_en,
  output logic              init_calib_complete,
  output logic [1:0]        state,
  output logic [7:0]        recal_count
);

  // ---------------------------------------------------------------------------
  // Sequence milestones, expressed as values of the sequence counter. The
  // counter holds the index of the edge about to happen, measured from the
  // origin edge (edge 0 after reset, or the edge that accepted a request).
  // ---------------------------------------------------------------------------
  localparam longint LAST_REL_L  = longint'(RESET_CYCLES)
                                 + longint'(NUM_CH - 1) * longint'(STAGGER_CYCLES);
  localparam longint DONE_EDGE_L = LAST_REL_L + longint'(CALIB_CYCLES);

  localparam logic [CNT_W-1:0] R_C        = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] LAST_REL_C = CNT_W'(LAST_REL_L);
  localparam logic [CNT_W-1:0] DONE_C     = CNT_W'(DONE_EDGE_L);

  // Elaboration-time parameter sanity checks
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("clk_rst_sequencer: NUM_CH must be in 1..16");
  end
  if (RESET_CYCLES < 1 || STAGGER_CYCLES < 1 || CALIB_CYCLES < 1) begin : g_bad_cycles
    $error("clk_rst_sequencer: RESET/STAGGER/CALIB_CYCLES must be >= 1");
  end
  if ((DONE_EDGE_L >> CNT_W) != longint'(0)) begin : g_cnt_too_narrow
    $error("clk_rst_sequencer: CNT_W too small, sequence counter would wrap");
  end

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_CALIB   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Terminal value of channel ch's divider (DIV-1). A divide value of 0 is
  // treated as 1, so its terminal value is 0 as well.
  function automatic logic [DIV_W-1:0] div_last(input int ch);
    logic [DIV_W-1:0] v;
    v = CH_DIV[ch*DIV_W +: DIV_W];
    if (v == {DIV_W{1'b0}}) begin
      return {DIV_W{1'b0}};
    end else begin
      return v - DIV_W'(1);
    end
  endfunction

  // Counter value at which channel ch leaves reset (R + ch*S)
  function automatic logic [CNT_W-1:0] rel_edge(input int ch);
    return CNT_W'(longint'(RESET_CYCLES) + longint'(ch) * longint'(STAGGER_CYCLES));
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_eff_s;
  logic [NUM_CH-1:0]  ch_reset_q, ch_reset_d;
  logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
  logic               icc_q, icc_d;
  logic [7:0]         recal_cnt_q, recal_cnt_d;
  logic [DIV_W-1:0]   div_q [NUM_CH];
  logic [DIV_W-1:0]   div_d [NUM_CH];

  // State register and all output / counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      cnt_q       <= {CNT_W{1'b0}};
      ch_reset_q  <= {NUM_CH{1'b1}};
      ch_en_q     <= {NUM_CH{1'b0}};
      icc_q       <= 1'b0;
      recal_cnt_q <= 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= {DIV_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_reset_q  <= ch_reset_d;
      ch_en_q     <= ch_en_d;
      icc_q       <= icc_d;
      recal_cnt_q <= recal_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
      end
    end
  end

  // Next-state logic. Before DONE, the state follows directly from the
  // counter. This lets RELEASE go straight to DONE when CALIB_CYCLES is 1.
  always_comb begin
    state_d = state_q;
    if (recal_req) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET, ST_RELEASE, ST_CALIB: begin
          if (cnt_q >= DONE_C) begin
            state_d = ST_DONE;
          end else if (cnt_q > LAST_REL_C) begin
            state_d = ST_CALIB;
          end else if (cnt_q >= R_C) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_RESET;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // Output / counter next values
  always_comb begin
    // An accepted request makes this edge the new origin (edge 0), so the
    // decisions below see a counter of 0.
    cnt_eff_s = recal_req ? {CNT_W{1'b0}} : cnt_q;

    // The counter stops once DONE is reached, so it never exceeds DONE_C.
    if (recal_req) begin
      cnt_d = CNT_W'(1);
    end else if (state_d == ST_DONE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Channel i is in reset until its release edge. The counter is frozen
    // beyond every release edge in DONE, so released channels stay released.
    for (int i = 0; i < NUM_CH; i++) begin
      ch_reset_d[i] = (cnt_eff_s < rel_edge(i));
    end

    // Dividers run only while the registered channel reset is low. The first
    // pulse therefore lands DIV edges after the release edge.
    for (int i = 0; i < NUM_CH; i++) begin
      if (recal_req || ch_reset_q[i]) begin
        div_d[i]   = {DIV_W{1'b0}};
        ch_en_d[i] = 1'b0;
      end else if (div_q[i] == div_last(i)) begin
        div_d[i]   = {DIV_W{1'b0}};
        ch_en_d[i] = 1'b1;
      end else begin
        div_d[i]   = div_q[i] + DIV_W'(1);
        ch_en_d[i] = 1'b0;
      end
    end

    icc_d = (state_d == ST_DONE);

    if (recal_req && (recal_cnt_q != 8'hFF)) begin
      recal_cnt_d = recal_cnt_q + 8'd1;
    end else begin
      recal_cnt_d = recal_cnt_q;
    end
  end

  assign ch_reset            = ch_reset_q;
  assign ch_en               = ch_en_q;
  assign init_calib_complete = icc_q;
  assign state               = state_q;
  assign recal_count         = recal_cnt_q;

endmodule
